viterbi_traceback: RTL and testbench

Survivor-path memory and traceback stage of the 4-state (K=3) Viterbi decoder. Sits directly downstream of the ACS unit. It stores the four per-step ACS selection bits for one frame and latches the final ACS path costs. On frame end it traces back from the best (or known) final state and emits the decoded bits in forward order over a valid/ready handshake.

---
 rtl/viterbi_traceback.sv | 159 +++++++++++++++
 tb/tb_viterbi_traceback.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Survivor-path memory and traceback for a 4-state (K=3) Viterbi decoder.
// It collects one frame of ACS decisions, traces back from the chosen final state, and emits the decoded bits oldest first.
module viterbi_traceback #(
    parameter int MAX_LEN    = 32,
    parameter bit TERMINATED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    input  logic       ACS00_selection,
    input  logic       ACS01_selection,
    input  logic       ACS10_selection,
    input  logic       ACS11_selection,
    input  logic [3:0] ACS00_path_cost,
    input  logic [3:0] ACS01_path_cost,
    input  logic [3:0] ACS10_path_cost,
    input  logic [3:0] ACS11_path_cost,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        COLLECT,
        TRACE,
        EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [1:0]    s_q, s_d;

    logic [3:0]    dec_mem [MAX_LEN];
    logic          out_mem [MAX_LEN];
    logic          dec_we;
    logic          out_we;
    logic [3:0]    dec_rd;

    logic [3:0]    cost [4];
    logic [1:0]    best_idx;
    logic [3:0]    best_cost;

    assign cost[0] = ACS00_path_cost;
    assign cost[1] = ACS01_path_cost;
    assign cost[2] = ACS10_path_cost;
    assign cost[3] = ACS11_path_cost;
    assign dec_rd  = dec_mem[i_q];

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx  = 2'd0;
        best_cost = cost[0];
        for (int j = 1; j < 4; j++) begin
            if (cost[j] < best_cost) begin
                best_idx  = 2'(j);
                best_cost = cost[j];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        i_d       = i_q;
        rd_d      = rd_q;
        s_d       = s_q;
        dec_we    = 1'b0;
        out_we    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            COLLECT: begin
                in_ready = !rst;
                if (in_valid && in_ready) begin
                    dec_we = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (in_last || (cnt_q == CW'(MAX_LEN - 1))) begin
                        len_d   = cnt_q + CW'(1);
                        i_d     = IW'(cnt_q);
                        s_d     = TERMINATED ? 2'b00 : best_idx;
                        state_d = TRACE;
                    end
                end
            end

            TRACE: begin
                // The step holding s decodes to s[1]; its predecessor is {s[0], decision}.
                out_we = 1'b1;
                s_d    = {s_q[0], dec_rd[s_q]};
                if (i_q == '0) begin
                    rd_d    = '0;
                    state_d = EMIT;
                end else begin
                    i_d = i_q - IW'(1);
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                out_bit   = out_mem[rd_q];
                out_last  = (CW'(rd_q) == len_q - CW'(1));
                if (out_ready) begin
                    if (out_last) begin
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end

            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            rd_q    <= '0;
            s_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            i_q     <= i_d;
            rd_q    <= rd_d;
            s_q     <= s_d;
        end
    end

    // NOTE: the memories have no reset; every entry is written before it is read within a frame.
    always_ff @(posedge clk) begin
        if (dec_we) begin
            dec_mem[cnt_q[IW-1:0]] <= {ACS11_selection, ACS10_selection,
                                       ACS01_selection, ACS00_selection};
        end
        if (out_we) begin
            out_mem[i_q] <= s_q[1];
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: a free-start and a zero-tailed instance share the same stimulus.
module tb_viterbi_traceback;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic       sel00, sel01, sel10, sel11;
    logic [3:0] c00, c01, c10, c11;

    logic       in_ready, out_valid, out_bit, out_last;
    logic       t_in_ready, t_out_valid, t_out_bit, t_out_last;

    int tests = 0;
    int fails = 0;

    viterbi_traceback #(.MAX_LEN(32), .TERMINATED(1'b0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .ACS00_selection(sel00), .ACS01_selection(sel01),
        .ACS10_selection(sel10), .ACS11_selection(sel11),
        .ACS00_path_cost(c00), .ACS01_path_cost(c01),
        .ACS10_path_cost(c10), .ACS11_path_cost(c11),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last)
    );

    viterbi_traceback #(.MAX_LEN(32), .TERMINATED(1'b1)) dut_t (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_last(in_last),
        .ACS00_selection(sel00), .ACS01_selection(sel01),
        .ACS10_selection(sel10), .ACS11_selection(sel11),
        .ACS00_path_cost(c00), .ACS01_path_cost(c01),
        .ACS10_path_cost(c10), .ACS11_path_cost(c11),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_bit(t_out_bit), .out_last(t_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Costs packed as {c11, c10, c01, c00}; step k's selections in sels[4k+:4] as {11,10,01,00}.
    task automatic send_frame(input int n, input logic [127:0] sels,
                              input logic [15:0] cost_last, input logic [15:0] cost_other,
                              input bit use_last);
        for (int k = 0; k < n; k++) begin
            logic [15:0] cv;
            check("in_ready_collect", {30'd0, in_ready, t_in_ready}, 32'd3);
            cv = (k == n - 1) ? cost_last : cost_other;
            {sel11, sel10, sel01, sel00} = sels[4*k +: 4];
            {c11, c10, c01, c00} = cv;
            in_valid = 1'b1;
            in_last  = use_last && (k == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        {sel11, sel10, sel01, sel00} = 4'hF;
        {c11, c10, c01, c00} = 16'h0000;
    endtask

    task automatic wait_valid(input int n);
        int k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        check("out_valid_latency", k, n);
    endtask

    // Expected bit for output position idx is exp[idx].
    task automatic recv_frame(input int n, input logic [31:0] exp, input logic [31:0] exp_t,
                              input bit toggle);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 400) begin
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            check($sformatf("emit_%0d", idx),
                  {26'd0, out_valid, out_bit, out_last, in_ready, t_out_bit, t_out_last},
                  {26'd0, 1'b1, exp[idx], (idx == n - 1), 1'b0, exp_t[idx], (idx == n - 1)});
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b1;
        check("emit_count", idx, n);
        check("after_last", {28'd0, out_valid, t_out_valid, in_ready, t_in_ready}, 32'h3);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        {sel11, sel10, sel01, sel00} = 4'h0;
        {c11, c10, c01, c00} = 16'h0000;
        repeat (3) tick();
        check("reset_outputs", {28'd0, in_ready, out_valid, out_bit, out_last}, 32'h0);
        check("reset_outputs_t", {28'd0, t_in_ready, t_out_valid, t_out_bit, t_out_last}, 32'h0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", {30'd0, in_ready, t_in_ready}, 32'd3);

        // Known path: start 11 gives 1,0,1,1; the zero-tailed copy gives all zeros.
        send_frame(4, 128'h400, 16'h0765, 16'h0000, 1'b1);
        check("in_ready_trace", {30'd0, in_ready, t_in_ready}, 32'd0);
        wait_valid(4);
        recv_frame(4, 32'hD, 32'h0, 1'b0);

        // Equal costs resolve to state 00.
        send_frame(4, 128'h400, 16'h3333, 16'h0000, 1'b1);
        wait_valid(4);
        recv_frame(4, 32'h0, 32'h0, 1'b0);

        // Cost minimum at 11 while the zero-tailed copy still starts at 00; output under backpressure.
        send_frame(4, 128'h400, 16'h0999, 16'h0000, 1'b1);
        wait_valid(4);
        recv_frame(4, 32'hD, 32'h0, 1'b1);

        // Forced end at MAX_LEN with all decisions 1 and minimum cost at 01.
        send_frame(32, {32{4'hF}}, 16'h8828, 16'h8828, 1'b0);
        check("in_ready_forced_end", {30'd0, in_ready, t_in_ready}, 32'd0);
        wait_valid(32);
        recv_frame(32, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0);

        // Single-step frame, minimum cost at 10.
        send_frame(1, 128'h0, 16'hF1F2, 16'h0000, 1'b1);
        wait_valid(1);
        recv_frame(1, 32'h1, 32'h0, 1'b0);

        // Reset in the middle of traceback, then a clean frame.
        send_frame(4, 128'h400, 16'h0765, 16'h0000, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_trace", {28'd0, out_valid, t_out_valid, in_ready, t_in_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst_mid", {30'd0, in_ready, t_in_ready}, 32'd3);
        send_frame(4, 128'h400, 16'h0765, 16'h0000, 1'b1);
        wait_valid(4);
        recv_frame(4, 32'hD, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
